tiempo_cfg: RTL and testbench
=============================

Name: tiempo_cfg

Overview:
Parametrised time-of-day counter (hh:mm:ss, 24 h internal) driven from the system clock through a configurable prescaler with a speed-up factor. Adds the following over the fixed-rate counter:
- run/hold control
- validated time-set handshake
- one-cycle carry pulses (sec/min/hour/day) for downstream game logic
- 12 h display output with AM/PM flag
Sits between the board clock and the pet-state / display blocks.

Parameters:
- CLK_FREQ, 50000000, input clock frequency in Hz
- SPEED, 1, simulated seconds per real second; prescaler terminal count = CLK_FREQ/SPEED - 1. CLK_FREQ/SPEED must be an integer ≥ 2.
- CNT_W, $clog2(CLK_FREQ/SPEED), prescaler counter width (derived; do not override)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- en  in  1  1 = run, 0 = hold (time and prescaler frozen)
- mode_12h  in  1  selects 12 h display encoding
- set_valid  in  1  time-load request
- set_ready  out  1  block can accept a load this cycle
- set_sec  in  6  load value, seconds
- set_min  in  6  load value, minutes
- set_hour  in  5  load value, hours (0-23)
- set_err  out  1  one-cycle pulse: load rejected (out of range)
- sec  out  6  seconds 0-59
- min  out  6  minutes 0-59
- hour  out  5  hours 0-23
- hour_disp  out  5  display hour (1-12 in 12 h mode, else equals hour)
- pm  out  1  1 when hour ≥ 12 and mode_12h = 1, else 0
- sec_tick  out  1  one-cycle pulse when sec advances
- min_tick  out  1  one-cycle pulse when sec wraps 59→0
- hour_tick  out  1  one-cycle pulse when min wraps 59→0
- day_tick  out  1  one-cycle pulse on 23:59:59→00:00:00

Behaviour:
- Reset (rst = 0, async):
  - sec = min = hour = 0, prescaler = 0, FSM = HOLD.
  - All tick pulses and set_err = 0; set_ready = 0 while rst is low.
- FSM states: RUN, HOLD, LOAD.
  - RUN→HOLD when en = 0.
  - HOLD→RUN when en = 1.
  - RUN/HOLD→LOAD on accepted set (set_valid & set_ready & in-range).
  - LOAD lasts exactly one cycle, then goes to RUN if en = 1, else HOLD.
- set_ready = 1 in RUN and HOLD; 0 in LOAD.
- Load acceptance:
  - In range means set_sec ≤ 59, set_min ≤ 59, set_hour ≤ 23.
  - Accepted: new time is visible on sec/min/hour the next cycle; prescaler cleared to 0; no tick pulses generated by the load.
  - Rejected: time and FSM unchanged; set_err pulses high for the cycle after the request.
- Prescaler:
  - Counts only in RUN (not in LOAD or HOLD).
  - At terminal count it returns to 0 and the time advances by one second.
- Time advance is registered. Tick pulses are asserted in the same cycle the new value appears on the outputs.
  - min_tick coincides with sec_tick.
  - hour_tick coincides with min_tick.
  - day_tick coincides with all three.
- Simultaneity:
  - An accepted load in the same cycle as prescaler terminal: load wins and the second increment is dropped.
  - en falling in the terminal cycle: the increment still occurs (en is sampled for the next cycle).
- hour_disp / pm: combinational from registered hour.
  - 0→12 AM; 1-11→AM; 12→12 PM; 13-23→hour-12 PM.
  - In 24 h mode: hour_disp = hour, pm = 0.
- Arithmetic: all compares are on full field width; no value outside its range is ever stored.

Optional Feature:
TIEMPO_ALARM_EN
- With the macro defined:
  - Extra ports: alarm_hour in 5, alarm_min in 6, alarm_arm in 1, alarm_ack in 1, alarm_out out 1.
  - alarm_out is set on the sec_tick where the new time equals alarm_hour:alarm_min:00 and alarm_arm = 1.
  - alarm_out stays high until alarm_ack = 1 (clears next cycle). Ack has priority over a simultaneous set.
  - Reset value of alarm_out is 0.
  - A load that lands exactly on the alarm time does not fire it.
- Without the macro: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package tiempo_pkg holds:
  - field widths SEC_W = 6, MIN_W = 6, HOUR_W = 5
  - limits SEC_MAX = 59, MIN_MAX = 59, HOUR_MAX = 23
  - FSM state enum (RUN, HOLD, LOAD)
- One sub-module, tiempo_prescaler:
  - parameters CLK_FREQ, SPEED
  - inputs clk, rst, run, clear; output one-cycle terminal pulse

Test Plan (all with CLK_FREQ = 10, SPEED = 1, i.e. 10 cycles per second):
- Release rst with en = 1 → first sec_tick exactly 10 cycles after entering RUN; sec = 1; min/hour unchanged.
- Load 23:59:58, run 20 cycles → two sec_ticks. Second shows 00:00:00 with sec_tick, min_tick, hour_tick and day_tick all high in the same single cycle.
- Load sec = 60 (also min = 60, hour = 24 separately) → set_err pulses 1 cycle; time unchanged; set_ready stays 1.
- Drop en mid-count (prescaler = 5) for 30 cycles, then raise it → no ticks while held; next sec_tick 5 cycles after resuming.
- mode_12h = 1, load hour 0, 11, 12, 13 → hour_disp/pm = 12/0, 11/0, 12/1, 1/1. With mode_12h = 0: hour_disp = hour, pm = 0.
- TIEMPO_ALARM_EN build: arm 00:01, load 00:00:59 → alarm_out high on the next sec_tick, held until alarm_ack, then 0. Assert rst mid-alarm → 0 immediately.

Source files
------------

// File: rtl/tiempo_pkg.sv
// Shared field widths, range limits and FSM encoding for the tiempo time-of-day counter.
package tiempo_pkg;

  localparam int SEC_W  = 6;
  localparam int MIN_W  = 6;
  localparam int HOUR_W = 5;

  localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;
  localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
  localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;
  localparam logic [HOUR_W-1:0] NOON     = 5'd12;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    HOLD = 2'd1,
    LOAD = 2'd2
  } state_t;

  // A load is only legal when every field lies inside its own range.
  function automatic logic time_in_range(
    input logic [SEC_W-1:0]  s,
    input logic [MIN_W-1:0]  m,
    input logic [HOUR_W-1:0] h
  );
    return (s <= SEC_MAX) && (m <= MIN_MAX) && (h <= HOUR_MAX);
  endfunction

endpackage

// File: rtl/tiempo_prescaler.sv
// Divides clk down to one simulated second; tick is high for the single cycle at terminal count.
module tiempo_prescaler #(
  parameter int CLK_FREQ = 50000000,
  parameter int SPEED    = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clear,
  output logic tick
);

  localparam int DIV   = CLK_FREQ / SPEED;
  localparam int CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] TC = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt_reg;
    if (clear) begin
      cnt_next = '0;
    end else if (run) begin
      cnt_next = (cnt_reg == TC) ? '0 : cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign tick = run && (cnt_reg == TC);

endmodule

// File: rtl/tiempo_cfg.sv
// Time-of-day counter with run/hold, validated load handshake, carry pulses and 12 h display.
// Optional alarm comparator is compiled in when TIEMPO_ALARM_EN is defined.
module tiempo_cfg
  import tiempo_pkg::*;
#(
  parameter int CLK_FREQ = 50000000,
  parameter int SPEED    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              mode_12h,
  input  logic              set_valid,
  output logic              set_ready,
  input  logic [SEC_W-1:0]  set_sec,
  input  logic [MIN_W-1:0]  set_min,
  input  logic [HOUR_W-1:0] set_hour,
  output logic              set_err,
  output logic [SEC_W-1:0]  sec,
  output logic [MIN_W-1:0]  min,
  output logic [HOUR_W-1:0] hour,
  output logic [HOUR_W-1:0] hour_disp,
  output logic              pm,
  output logic              sec_tick,
  output logic              min_tick,
  output logic              hour_tick,
  output logic              day_tick
`ifdef TIEMPO_ALARM_EN
  ,
  input  logic [HOUR_W-1:0] alarm_hour,
  input  logic [MIN_W-1:0]  alarm_min,
  input  logic              alarm_arm,
  input  logic              alarm_ack,
  output logic              alarm_out
`endif
);

  state_t state_reg, state_next;

  logic [SEC_W-1:0]  sec_reg, sec_next;
  logic [MIN_W-1:0]  min_reg, min_next;
  logic [HOUR_W-1:0] hour_reg, hour_next;

  logic sec_tick_reg, sec_tick_next;
  logic min_tick_reg, min_tick_next;
  logic hour_tick_reg, hour_tick_next;
  logic day_tick_reg, day_tick_next;
  logic set_err_reg;

  logic set_ok;
  logic accept;
  logic reject;
  logic tc;
  logic sec_wrap;
  logic min_wrap;
  logic hour_wrap;

  // Ready is forced low during reset even though the state register already reads HOLD.
  assign set_ready = rst && (state_reg != LOAD);
  assign set_ok    = time_in_range(set_sec, set_min, set_hour);
  assign accept    = set_valid && set_ready && set_ok;
  assign reject    = set_valid && set_ready && !set_ok;

  tiempo_prescaler #(
    .CLK_FREQ (CLK_FREQ),
    .SPEED    (SPEED)
  ) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .run   (state_reg == RUN),
    .clear (accept),
    .tick  (tc)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RUN: begin
        if (accept)   state_next = LOAD;
        else if (!en) state_next = HOLD;
      end
      HOLD: begin
        if (accept)   state_next = LOAD;
        else if (en)  state_next = RUN;
      end
      LOAD:    state_next = en ? RUN : HOLD;
      default: state_next = HOLD;
    endcase
  end

  // ">=" rather than "==" so a corrupted field can never walk past its limit.
  assign sec_wrap  = (sec_reg >= SEC_MAX);
  assign min_wrap  = (min_reg >= MIN_MAX);
  assign hour_wrap = (hour_reg >= HOUR_MAX);

  // An accepted load takes priority over a coincident second and suppresses every carry pulse.
  always_comb begin
    sec_next       = sec_reg;
    min_next       = min_reg;
    hour_next      = hour_reg;
    sec_tick_next  = 1'b0;
    min_tick_next  = 1'b0;
    hour_tick_next = 1'b0;
    day_tick_next  = 1'b0;
    if (accept) begin
      sec_next  = set_sec;
      min_next  = set_min;
      hour_next = set_hour;
    end else if (tc) begin
      sec_tick_next = 1'b1;
      if (sec_wrap) begin
        sec_next      = '0;
        min_tick_next = 1'b1;
        if (min_wrap) begin
          min_next       = '0;
          hour_tick_next = 1'b1;
          if (hour_wrap) begin
            hour_next     = '0;
            day_tick_next = 1'b1;
          end else begin
            hour_next = hour_reg + 5'd1;
          end
        end else begin
          min_next = min_reg + 6'd1;
        end
      end else begin
        sec_next = sec_reg + 6'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= HOLD;
      sec_reg       <= '0;
      min_reg       <= '0;
      hour_reg      <= '0;
      sec_tick_reg  <= 1'b0;
      min_tick_reg  <= 1'b0;
      hour_tick_reg <= 1'b0;
      day_tick_reg  <= 1'b0;
      set_err_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      sec_reg       <= sec_next;
      min_reg       <= min_next;
      hour_reg      <= hour_next;
      sec_tick_reg  <= sec_tick_next;
      min_tick_reg  <= min_tick_next;
      hour_tick_reg <= hour_tick_next;
      day_tick_reg  <= day_tick_next;
      set_err_reg   <= reject;
    end
  end

  assign sec       = sec_reg;
  assign min       = min_reg;
  assign hour      = hour_reg;
  assign sec_tick  = sec_tick_reg;
  assign min_tick  = min_tick_reg;
  assign hour_tick = hour_tick_reg;
  assign day_tick  = day_tick_reg;
  assign set_err   = set_err_reg;

  // Midnight shows as 12 AM and noon as 12 PM; afternoon hours fold down by twelve.
  always_comb begin
    hour_disp = hour_reg;
    pm        = 1'b0;
    if (mode_12h) begin
      pm = (hour_reg >= NOON);
      if (hour_reg == '0) begin
        hour_disp = NOON;
      end else if (hour_reg > NOON) begin
        hour_disp = hour_reg - NOON;
      end
    end
  end

`ifdef TIEMPO_ALARM_EN
  logic alarm_reg, alarm_next;
  logic alarm_hit;

  // Only a counted second can fire the alarm, so a load landing on the alarm time stays silent.
  assign alarm_hit = sec_tick_next && alarm_arm && (sec_next == '0) &&
                     (min_next == alarm_min) && (hour_next == alarm_hour);

  always_comb begin
    alarm_next = alarm_reg;
    if (alarm_ack) begin
      alarm_next = 1'b0;
    end else if (alarm_hit) begin
      alarm_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alarm_reg <= 1'b0;
    end else begin
      alarm_reg <= alarm_next;
    end
  end

  assign alarm_out = alarm_reg;
`endif

endmodule

// File: tb/tb_tiempo_cfg.sv
// Randomised and directed bench for tiempo_cfg against a seconds-of-day reference model.
module tb_tiempo_cfg;

  localparam int DIV = 10;

  logic       clk;
  logic       rst;
  logic       en;
  logic       mode_12h;
  logic       set_valid;
  logic       set_ready;
  logic [5:0] set_sec;
  logic [5:0] set_min;
  logic [4:0] set_hour;
  logic       set_err;
  logic [5:0] sec;
  logic [5:0] min;
  logic [4:0] hour;
  logic [4:0] hour_disp;
  logic       pm;
  logic       sec_tick;
  logic       min_tick;
  logic       hour_tick;
  logic       day_tick;
`ifdef TIEMPO_ALARM_EN
  logic [4:0] alarm_hour;
  logic [5:0] alarm_min;
  logic       alarm_arm;
  logic       alarm_ack;
  logic       alarm_out;
  int         m_alarm;
`endif

  int errors;
  int checks;

  // Reference model: time as seconds since midnight, prescaler phase, mode 0=run 1=hold 2=load.
  int m_tod;
  int m_pre;
  int m_mode;
  int m_err;

  tiempo_cfg #(
    .CLK_FREQ (10),
    .SPEED    (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .mode_12h   (mode_12h),
    .set_valid  (set_valid),
    .set_ready  (set_ready),
    .set_sec    (set_sec),
    .set_min    (set_min),
    .set_hour   (set_hour),
    .set_err    (set_err),
    .sec        (sec),
    .min        (min),
    .hour       (hour),
    .hour_disp  (hour_disp),
    .pm         (pm),
    .sec_tick   (sec_tick),
    .min_tick   (min_tick),
    .hour_tick  (hour_tick),
    .day_tick   (day_tick)
`ifdef TIEMPO_ALARM_EN
    ,
    .alarm_hour (alarm_hour),
    .alarm_min  (alarm_min),
    .alarm_arm  (alarm_arm),
    .alarm_ack  (alarm_ack),
    .alarm_out  (alarm_out)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] exp_disp(input int h, input logic m12);
    if (!m12)   return {1'b0, 5'(h)};
    if (h == 0) return {1'b0, 5'd12};
    if (h < 12) return {1'b0, 5'(h)};
    if (h == 12) return {1'b1, 5'd12};
    return {1'b1, 5'(h - 12)};
  endfunction

  function automatic logic [16:0] exp_time();
    return {5'(m_tod / 3600), 6'((m_tod / 60) % 60), 6'(m_tod % 60)};
  endfunction

  function automatic int obs_ticks();
    return int'({day_tick, hour_tick, min_tick, sec_tick});
  endfunction

  // One clock: check combinational outputs mid-cycle, advance the model, check registers after the edge.
  task automatic step();
    bit         ok;
    bit         acc;
    bit         rej;
    bit         term;
    logic [3:0] e_ticks;
    e_ticks = '0;
    @(negedge clk);
    check("set_ready", 32'(set_ready), 32'(m_mode != 2));
    check("disp", 32'({pm, hour_disp}), 32'(exp_disp(m_tod / 3600, mode_12h)));
    ok   = (set_sec <= 59) && (set_min <= 59) && (set_hour <= 23);
    acc  = set_valid && (m_mode != 2) && ok;
    rej  = set_valid && (m_mode != 2) && !ok;
    term = (m_mode == 0) && (m_pre == DIV - 1);
    if (acc) begin
      m_tod = int'(set_hour) * 3600 + int'(set_min) * 60 + int'(set_sec);
      m_pre = 0;
    end else begin
      if (m_mode == 0) m_pre = term ? 0 : m_pre + 1;
      if (term) begin
        m_tod   = (m_tod + 1) % 86400;
        e_ticks = {m_tod == 0, m_tod % 3600 == 0, m_tod % 60 == 0, 1'b1};
      end
    end
    m_mode = acc ? 2 : (en ? 0 : 1);
    m_err  = rej ? 1 : 0;
`ifdef TIEMPO_ALARM_EN
    if (alarm_ack) m_alarm = 0;
    else if (e_ticks[0] && alarm_arm &&
             m_tod == int'(alarm_hour) * 3600 + int'(alarm_min) * 60) m_alarm = 1;
`endif
    @(posedge clk);
    #1;
    check("time", 32'({hour, min, sec}), 32'(exp_time()));
    check("ticks", 32'(obs_ticks()), 32'(e_ticks));
    check("set_err", 32'(set_err), 32'(m_err));
`ifdef TIEMPO_ALARM_EN
    check("alarm_out", 32'(alarm_out), 32'(m_alarm));
`endif
  endtask

  task automatic do_set(input int h, input int m, input int s);
    set_hour  = 5'(h);
    set_min   = 6'(m);
    set_sec   = 6'(s);
    set_valid = 1'b1;
    $display("txn set %02d:%02d:%02d en=%0d mode_12h=%0d", h, m, s, en, mode_12h);
    step();
    set_valid = 1'b0;
  endtask

  task automatic model_reset();
    m_tod  = 0;
    m_pre  = 0;
    m_mode = 1;
    m_err  = 0;
`ifdef TIEMPO_ALARM_EN
    m_alarm = 0;
`endif
  endtask

  initial begin
    #400000;
    errors++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    int first;
    int nsec;
    int nday;
    int nt;
    int resume;
    int hrs[4];
    logic [5:0] disp12[4];
    hrs    = '{0, 11, 12, 13};
    disp12 = '{6'd12, 6'd11, 6'h2C, 6'h21};
    errors    = 0;
    checks    = 0;
    rst       = 1'b0;
    en        = 1'b1;
    mode_12h  = 1'b0;
    set_valid = 1'b0;
    set_sec   = '0;
    set_min   = '0;
    set_hour  = '0;
`ifdef TIEMPO_ALARM_EN
    alarm_hour = '0;
    alarm_min  = '0;
    alarm_arm  = 1'b0;
    alarm_ack  = 1'b0;
`endif
    model_reset();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_time", 32'({hour, min, sec}), 32'(0));
    check("rst_ticks", 32'(obs_ticks()), 32'(0));
    check("rst_err", 32'(set_err), 32'(0));
    check("rst_ready", 32'(set_ready), 32'(0));
    rst = 1'b1;
    $display("txn release reset en=1");

    // First second after release
    first = 0;
    for (int i = 1; i <= 20 && first == 0; i++) begin
      step();
      if (sec_tick) first = i;
    end
    check("first_tick_cycle", 32'(first), 32'(11));
    check("sec_after_first", 32'(sec), 32'(1));

    // Midnight rollover
    do_set(23, 59, 58);
    nsec = 0;
    nday = 0;
    repeat (21) begin
      step();
      nsec += int'(sec_tick);
      nday += int'(day_tick);
    end
    check("two_sec_ticks", 32'(nsec), 32'(2));
    check("one_day_tick", 32'(nday), 32'(1));

    // Out-of-range loads
    do_set(0, 0, 60);
    check("reject_sec_err", 32'(set_err), 32'(1));
    check("reject_sec_ready", 32'(set_ready), 32'(1));
    do_set(0, 60, 0);
    check("reject_min_err", 32'(set_err), 32'(1));
    do_set(24, 0, 0);
    check("reject_hour_err", 32'(set_err), 32'(1));
    step();

    // Hold mid-count
    for (int i = 0; i < 40 && !(m_mode == 0 && m_pre == 5); i++) step();
    check("reach_pre5", 32'(m_mode == 0 && m_pre == 5), 32'(1));
    en = 1'b0;
    $display("txn hold en=0 for 30 cycles");
    nt = 0;
    repeat (30) begin
      step();
      nt += int'(sec_tick);
    end
    check("ticks_while_held", 32'(nt), 32'(0));
    en = 1'b1;
    $display("txn resume en=1");
    resume = 0;
    for (int i = 1; i <= 20 && resume == 0; i++) begin
      step();
      if (sec_tick) resume = i;
    end
    check("resume_tick_cycle", 32'(resume), 32'(5));

    // Display encoding
    for (int i = 0; i < 4; i++) begin
      mode_12h = 1'b1;
      do_set(hrs[i], 0, 0);
      check("disp12", 32'({pm, hour_disp}), 32'(disp12[i]));
      mode_12h = 1'b0;
      #1;
      check("disp24", 32'({pm, hour_disp}), 32'(hrs[i]));
      step();
    end

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      en       = ($urandom_range(0, 7) != 0);
      mode_12h = 1'($urandom_range(0, 1));
`ifdef TIEMPO_ALARM_EN
      alarm_arm  = 1'($urandom_range(0, 1));
      alarm_ack  = ($urandom_range(0, 5) == 0);
      alarm_hour = 5'(m_tod / 3600);
      alarm_min  = 6'((m_tod / 60 + int'($urandom_range(0, 1))) % 60);
`endif
      if ($urandom_range(0, 9) == 0)
        do_set(int'($urandom_range(0, 31)), int'($urandom_range(0, 63)), int'($urandom_range(0, 63)));
      else
        step();
    end

`ifdef TIEMPO_ALARM_EN
    // Alarm behaviour
    en         = 1'b1;
    mode_12h   = 1'b0;
    alarm_arm  = 1'b1;
    alarm_ack  = 1'b1;
    alarm_hour = 5'd0;
    alarm_min  = 6'd1;
    step();
    step();
    alarm_ack = 1'b0;
    do_set(0, 0, 59);
    first = 0;
    for (int i = 1; i <= 30 && first == 0; i++) begin
      step();
      if (alarm_out) first = i;
    end
    check("alarm_fire_cycle", 32'(first), 32'(11));
    repeat (5) step();
    check("alarm_held", 32'(alarm_out), 32'(1));
    alarm_ack = 1'b1;
    $display("txn alarm ack");
    step();
    alarm_ack = 1'b0;
    check("alarm_acked", 32'(alarm_out), 32'(0));
    step();
    do_set(0, 1, 0);
    repeat (3) step();
    check("alarm_load_no_fire", 32'(alarm_out), 32'(0));
    do_set(0, 0, 59);
    first = 0;
    for (int i = 1; i <= 30 && first == 0; i++) begin
      step();
      if (alarm_out) first = i;
    end
    check("alarm_refire", 32'(first != 0), 32'(1));
    rst = 1'b0;
    $display("txn async reset mid-alarm");
    #1;
    check("alarm_async_rst", 32'(alarm_out), 32'(0));
    check("time_async_rst", 32'({hour, min, sec}), 32'(0));
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (5) step();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
